// File: rtl/mb_eye_width_sweep.sv
// Mainband eye-width sweep engine: steps the PI code over 0..PI_MAX, runs one point
// test per code, and reports per-lane pass, the widest all-lane eye centre and an ack.
module mb_eye_width_sweep #(
  parameter int LANES      = 16,
  parameter int PI_BITS    = 4,
  parameter int PI_MAX     = 15,
  parameter int MIN_EYE    = 4,
  parameter int SETTLE_CYC = 4,
  parameter int PT_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sweep_en,
  input  logic               i_pt_done,
  input  logic [LANES-1:0]   i_pt_lane_pass,
  output logic               o_pt_start,
  output logic [PI_BITS-1:0] o_pi_step,
  output logic [LANES-1:0]   o_tx_lanes_result,
  output logic [PI_BITS-1:0] o_eye_center,
  output logic               o_eye_valid,
  output logic               o_busy,
  output logic               o_test_ack
);

  localparam int CW = PI_BITS + 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TW = (PT_TIMEOUT > 1) ? $clog2(PT_TIMEOUT) : 1;
  localparam logic [SW-1:0]      SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(PT_TIMEOUT - 1);
  localparam logic [PI_BITS-1:0] CODE_LAST    = PI_BITS'(PI_MAX);
  localparam logic [CW-1:0]      MIN_EYE_C    = CW'(MIN_EYE);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_START, S_WAIT, S_UPDATE, S_DONE
  } state_t;

  state_t             state, state_n;
  logic               en_q;
  logic [SW-1:0]      settle_cnt;
  logic [TW-1:0]      wait_cnt;
  logic [PI_BITS-1:0] code;
  logic [LANES-1:0]   pass_q;
  logic [CW-1:0]      cur_run [LANES];
  logic [CW-1:0]      max_run [LANES];
  logic [CW-1:0]      cur_run_n [LANES];
  logic [CW-1:0]      max_run_n [LANES];
  logic [CW-1:0]      agg_cur, best_len, best_start;
  logic [CW-1:0]      agg_cur_n, best_len_n, best_start_n;
  logic [LANES-1:0]   lanes_ok;
  logic [PI_BITS-1:0] center_n;
  logic               sweep_go, abort_go;

  function automatic logic [CW-1:0] run_next(input logic pass, input logic [CW-1:0] run);
    return pass ? run + CW'(1) : '0;
  endfunction

  function automatic logic [PI_BITS-1:0] eye_center(input logic [CW-1:0] start,
                                                    input logic [CW-1:0] len);
    logic [CW-1:0] mid;
    mid = start + ((len - CW'(1)) >> 1);
    return (len == '0) ? '0 : mid[PI_BITS-1:0];
  endfunction

  assign sweep_go   = (state == S_IDLE) && i_sweep_en && !en_q;
  assign abort_go   = (state inside {S_SETTLE, S_START, S_WAIT, S_UPDATE}) && !i_sweep_en;
  assign o_pt_start = (state == S_START);
  assign o_busy     = (state inside {S_SETTLE, S_START, S_WAIT, S_UPDATE});
  assign o_test_ack = (state == S_DONE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (sweep_go) state_n = S_SETTLE;
      S_SETTLE: if (!i_sweep_en) state_n = S_IDLE;
                else if (settle_cnt == SETTLE_LAST) state_n = S_START;
      S_START:  state_n = i_sweep_en ? S_WAIT : S_IDLE;
      S_WAIT:   if (!i_sweep_en) state_n = S_IDLE;
                else if (i_pt_done || (wait_cnt == TIMEOUT_LAST)) state_n = S_UPDATE;
      S_UPDATE: if (!i_sweep_en) state_n = S_IDLE;
                else if (code == CODE_LAST) state_n = S_DONE;
                else state_n = S_SETTLE;
      S_DONE:   if (!i_sweep_en) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Next run lengths as they will stand after the UPDATE cycle; the final UPDATE
  // feeds these straight into the DONE outputs.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cur_run_n[i] = run_next(pass_q[i], cur_run[i]);
      max_run_n[i] = (cur_run_n[i] > max_run[i]) ? cur_run_n[i] : max_run[i];
      lanes_ok[i]  = (max_run_n[i] >= MIN_EYE_C);
    end
    agg_cur_n    = run_next(&pass_q, agg_cur);
    best_len_n   = best_len;
    best_start_n = best_start;
    if (agg_cur_n > best_len) begin
      best_len_n   = agg_cur_n;
      best_start_n = {1'b0, code} - agg_cur_n + CW'(1);
    end
    center_n = eye_center(best_start_n, best_len_n);
  end

  // Control and output registers. en_q follows the pin even in reset so a level
  // held across reset release is not mistaken for a new request.
  always_ff @(posedge clk) begin
    en_q <= i_sweep_en;
    if (rst) begin
      state             <= S_IDLE;
      settle_cnt        <= '0;
      wait_cnt          <= '0;
      o_pi_step         <= '0;
      o_tx_lanes_result <= '0;
      o_eye_center      <= '0;
      o_eye_valid       <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + SW'(1) : '0;
      wait_cnt   <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
      if (sweep_go) begin
        o_pi_step         <= '0;
        o_tx_lanes_result <= '0;
        o_eye_center      <= '0;
        o_eye_valid       <= 1'b0;
      end else if (abort_go) begin
        o_pi_step <= '0;
      end else if (state == S_UPDATE) begin
        if (code == CODE_LAST) begin
          o_pi_step         <= center_n;
          o_tx_lanes_result <= lanes_ok;
          o_eye_center      <= center_n;
          o_eye_valid       <= (best_len_n >= MIN_EYE_C);
        end else begin
          o_pi_step <= code + PI_BITS'(1);
        end
      end
    end
  end

  // Sweep datapath; cleared at every sweep start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (sweep_go) begin
      code       <= '0;
      agg_cur    <= '0;
      best_len   <= '0;
      best_start <= '0;
      for (int i = 0; i < LANES; i++) begin
        cur_run[i] <= '0;
        max_run[i] <= '0;
      end
    end else if (state == S_UPDATE && i_sweep_en) begin
      agg_cur    <= agg_cur_n;
      best_len   <= best_len_n;
      best_start <= best_start_n;
      for (int i = 0; i < LANES; i++) begin
        cur_run[i] <= cur_run_n[i];
        max_run[i] <= max_run_n[i];
      end
      if (code != CODE_LAST) code <= code + PI_BITS'(1);
    end
    if (state == S_WAIT && state_n == S_UPDATE) pass_q <= i_pt_done ? i_pt_lane_pass : '0;
  end

endmodule

// File: tb/tb_mb_eye_width_sweep.sv
// Bench for mb_eye_width_sweep: plans a cycle-by-cycle timeline of stimulus and expected
// outputs from a window-search model, then replays it and compares every cycle.
module tb_mb_eye_width_sweep;
  localparam int NCYC = 4096;
  localparam int S    = 4;

  logic        clk = 1'b0;
  logic        rst, en, done;
  logic [15:0] pass;
  logic        pt_start, eye_valid, busy, test_ack;
  logic [3:0]  pi_step, eye_center;
  logic [15:0] lanes_result;

  mb_eye_width_sweep dut (
    .clk(clk), .rst(rst), .i_sweep_en(en), .i_pt_done(done), .i_pt_lane_pass(pass),
    .o_pt_start(pt_start), .o_pi_step(pi_step), .o_tx_lanes_result(lanes_result),
    .o_eye_center(eye_center), .o_eye_valid(eye_valid), .o_busy(busy), .o_test_ack(test_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input int cy, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cy, act, exp);
    end
  endtask

  // Planned stimulus and expectations, indexed by cycle
  bit          d_en [NCYC], d_rst [NCYC], d_done [NCYC];
  logic [15:0] d_pass [NCYC];
  bit          e_chk [NCYC], e_busy [NCYC], e_start [NCYC], e_ack [NCYC], e_vld [NCYC];
  logic [3:0]  e_pi [NCYC], e_ctr [NCYC];
  logic [15:0] e_res [NCYC];

  int          pc = 0, t_start = 0, t1 = 0, ack_rise = -1, cyc = 0;
  bit          en_lvl = 0, running = 0, ack_prev = 0;
  logic [3:0]  cur_pi = 0, cur_ctr = 0;
  logic [15:0] cur_res = 0;
  bit          cur_vld = 0;

  logic [15:0] s_pat [16];
  int          s_dly [16];
  logic [15:0] m_res;
  logic [3:0]  m_ctr;
  bit          m_vld;

  // Longest run search over the whole code range, first longest window wins
  task automatic model();
    logic [15:0] eff [16];
    int best, blen, bs, len;
    for (int c = 0; c < 16; c++) eff[c] = (s_dly[c] < 0) ? 16'h0 : s_pat[c];
    for (int i = 0; i < 16; i++) begin
      best = 0;
      for (int s0 = 0; s0 < 16; s0++) begin
        len = 0;
        while (s0 + len < 16 && eff[s0+len][i]) len++;
        if (len > best) best = len;
      end
      m_res[i] = (best >= 4);
    end
    blen = 0; bs = 0;
    for (int s0 = 0; s0 < 16; s0++) begin
      len = 0;
      while (s0 + len < 16 && (&eff[s0+len])) len++;
      if (len > blen) begin blen = len; bs = s0; end
    end
    m_ctr = (blen > 0) ? 4'(bs + (blen - 1) / 2) : 4'd0;
    m_vld = (blen >= 4);
  endtask

  task automatic step(input bit b, input bit st, input bit ak);
    if (pc >= NCYC) begin
      $display("FAIL plan_overflow cycle=%0d", pc);
      $fatal(1, "plan too long");
    end
    e_chk[pc] = 1; e_busy[pc] = b; e_start[pc] = st; e_ack[pc] = ak;
    e_pi[pc] = cur_pi; e_res[pc] = cur_res; e_ctr[pc] = cur_ctr; e_vld[pc] = cur_vld;
    d_en[pc] = en_lvl;
    pc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  function automatic logic [15:0] rand_fail();
    logic [15:0] r;
    r = 16'($urandom);
    r[$urandom_range(15, 0)] = 1'b0;
    return r;
  endfunction

  task automatic setup(input int lo, input int hi, input int dmin, input int dmax);
    for (int c = 0; c < 16; c++) begin
      s_pat[c] = (c >= lo && c <= hi) ? 16'hFFFF : rand_fail();
      s_dly[c] = int'($urandom_range(dmax, dmin));
    end
  endtask

  task automatic sweep(input int abort_c, input int rst_c);
    int n;
    t_start = pc;
    en_lvl = 1; step(0, 0, 0);
    cur_pi = 0; cur_res = 0; cur_ctr = 0; cur_vld = 0;
    for (int c = 0; c < 16; c++) begin
      cur_pi = 4'(c);
      for (int k = 0; k < S; k++) begin
        if (c == rst_c && k == 0) begin
          d_rst[pc] = 1; step(1, 0, 0); cur_pi = 0;
          return;
        end
        d_done[pc] = ($urandom_range(3, 0) == 0);
        d_pass[pc] = 16'($urandom);
        step(1, 0, 0);
      end
      step(1, 1, 0);
      if (c == abort_c) begin
        en_lvl = 0; step(1, 0, 0); cur_pi = 0;
        return;
      end
      n = (s_dly[c] < 0) ? 255 : s_dly[c];
      for (int k = 1; k <= n; k++) begin
        if (k == n && s_dly[c] >= 0) begin d_done[pc] = 1; d_pass[pc] = s_pat[c]; end
        else d_pass[pc] = 16'($urandom);
        step(1, 0, 0);
      end
      step(1, 0, 0);
    end
    model();
    cur_res = m_res; cur_ctr = m_ctr; cur_vld = m_vld; cur_pi = m_ctr;
    n = 1 + int'($urandom_range(3, 0));
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) en_lvl = 0;
      step(0, 0, 1);
    end
  endtask

  task automatic plan();
    int lo, hi;
    for (int t = 0; t < NCYC; t++) d_pass[t] = 16'h0;
    d_rst[0] = 1; pc = 1;
    d_rst[1] = 1; step(0, 0, 0);
    d_rst[2] = 1; step(0, 0, 0);
    idle(3);
    // all pass, fixed latency 2
    setup(0, 15, 2, 2); sweep(-1, -1); t1 = t_start;
    chk("pin_all_res", -1, m_res, 16'hFFFF);
    chk("pin_all_ctr", -1, 16'(m_ctr), 16'd7);
    chk("pin_all_vld", -1, 16'(m_vld), 16'd1);
    idle(3);
    // common window 3..10
    setup(3, 10, 1, 6); sweep(-1, -1);
    chk("pin_w310_ctr", -1, 16'(m_ctr), 16'd6);
    chk("pin_w310_res", -1, m_res, 16'hFFFF);
    idle(2);
    // lane 5 only 3..5
    setup(3, 10, 1, 6);
    for (int c = 0; c < 16; c++) if (c < 3 || c > 5) s_pat[c][5] = 1'b0;
    sweep(-1, -1);
    chk("pin_l5_res", -1, m_res, 16'hFFDF);
    chk("pin_l5_ctr", -1, 16'(m_ctr), 16'd4);
    chk("pin_l5_vld", -1, 16'(m_vld), 16'd0);
    idle(2);
    // two equal windows 1..4 and 9..12
    setup(1, 12, 1, 5);
    for (int c = 5; c <= 8; c++) s_pat[c] = rand_fail();
    sweep(-1, -1);
    chk("pin_tie_ctr", -1, 16'(m_ctr), 16'd2);
    idle(2);
    // timeout at code 8, result exactly at expiry on code 3
    setup(0, 15, 1, 4); s_dly[8] = -1; s_dly[3] = 255;
    sweep(-1, -1);
    chk("pin_tmo_ctr", -1, 16'(m_ctr), 16'd3);
    chk("pin_tmo_vld", -1, 16'(m_vld), 16'd1);
    idle(2);
    // abort in WAIT at code 5, then a clean restart
    setup(0, 15, 1, 4); sweep(5, -1); idle(3);
    setup(0, 15, 1, 4); sweep(-1, -1);
    idle(2);
    // reset in SETTLE with enable held high across release
    setup(0, 15, 1, 3); sweep(-1, 2);
    idle(6); en_lvl = 0; idle(2);
    setup(2, 9, 1, 4); sweep(-1, -1);
    chk("pin_w29_ctr", -1, 16'(m_ctr), 16'd5);
    idle(2);
    for (int r = 0; r < 3; r++) begin
      lo = int'($urandom_range(15, 0));
      hi = int'($urandom_range(15, lo));
      setup(lo, hi, 1, 8); sweep(-1, -1); idle(2);
    end
  endtask

  task automatic apply(input int t);
    rst = d_rst[t]; en = d_en[t]; done = d_done[t]; pass = d_pass[t];
  endtask

  always @(negedge clk) begin
    if (running && e_chk[cyc]) begin
      chk("busy",      cyc, 16'(busy),       16'(e_busy[cyc]));
      chk("pt_start",  cyc, 16'(pt_start),   16'(e_start[cyc]));
      chk("test_ack",  cyc, 16'(test_ack),   16'(e_ack[cyc]));
      chk("pi_step",   cyc, 16'(pi_step),    16'(e_pi[cyc]));
      chk("lanes_res", cyc, lanes_result,    e_res[cyc]);
      chk("eye_ctr",   cyc, 16'(eye_center), 16'(e_ctr[cyc]));
      chk("eye_valid", cyc, 16'(eye_valid),  16'(e_vld[cyc]));
      if (test_ack && !ack_prev && ack_rise < 0) ack_rise = cyc;
      ack_prev = test_ack;
    end
  end

  initial begin
    plan();
    running = 1;
    cyc = 0;
    apply(0);
    for (int t = 1; t < pc; t++) begin
      @(posedge clk);
      cyc = t;
      #1 apply(t);
    end
    @(negedge clk);
    #1 running = 0;
    chk("ack_latency", -1, 16'(ack_rise - t1), 16'd129);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
